// File: rtl/arb_pkg.sv
// Shared definitions for the 8-way round-robin arbiter.
// Holds requester count, index width and the FSM state encoding.
package arb_pkg;

  localparam int N     = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/rr_prio_pick.sv
// Rotated priority pick: first set bit of i_vec scanning from i_start upward, wrapping.
// Ports: i_vec (requests), i_start (scan origin), o_idx (winner), o_found (any bit set).
module rr_prio_pick
  import arb_pkg::*;
(
  input  logic [N-1:0]     i_vec,
  input  logic [IDX_W-1:0] i_start,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_found
);

  logic [2*N-1:0]   w_dbl;
  logic [N-1:0]     w_rot;
  logic [IDX_W-1:0] w_enc;

  // Rotate right by i_start so the scan origin lands on bit 0.
  assign w_dbl = {i_vec, i_vec};
  assign w_rot = w_dbl[i_start +: N];

  // Lowest set bit wins; iterate downward so the lowest assignment is last.
  always_comb begin
    w_enc = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_rot[i]) w_enc = IDX_W'(i);
    end
  end

  // Undo the rotation; 3-bit add wraps naturally.
  assign o_idx   = w_enc + i_start;
  assign o_found = |i_vec;

endmodule

// File: rtl/rr_arb8.sv
// Round-robin arbiter for 8 requesters with a per-owner hold limit.
// Ports: clk, rst (sync, active high), req[7:0]; gnt[7:0] one-hot, gnt_idx[2:0], gnt_valid.
module rr_arb8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  localparam int HW = $clog2(MAX_HOLD);

  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_ptr, w_ptr_nxt;
  logic [HW-1:0]    r_hold, w_hold_nxt;
  logic [N-1:0]     r_gnt, w_gnt_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic             r_valid, w_valid_nxt;

  logic [IDX_W-1:0] w_start;
  logic [IDX_W-1:0] w_pick;
  logic             w_found;
  logic [IDX_W-1:0] w_after;

  // While granted, the next owner is searched from just past the
  // current one; ptr only matters when coming out of IDLE.
  assign w_after = r_idx + IDX_W'(1);
  assign w_start = (r_state == GRANT) ? w_after : r_ptr;

  rr_prio_pick u_pick (
    .i_vec   (req),
    .i_start (w_start),
    .o_idx   (w_pick),
    .o_found (w_found)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_hold  <= '0;
      r_gnt   <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_hold  <= w_hold_nxt;
      r_gnt   <= w_gnt_nxt;
      r_idx   <= w_idx_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_hold_nxt  = r_hold;
    w_gnt_nxt   = r_gnt;
    w_idx_nxt   = r_idx;
    w_valid_nxt = r_valid;
    unique case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt = GRANT;
          w_idx_nxt   = w_pick;
          w_gnt_nxt   = N'(1) << w_pick;
          w_valid_nxt = 1'b1;
          w_hold_nxt  = '0;
        end
      end
      GRANT: begin
        if (!req[r_idx]) begin
          w_ptr_nxt  = w_after;
          w_hold_nxt = '0;
          if (w_found) begin
            w_idx_nxt = w_pick;
            w_gnt_nxt = N'(1) << w_pick;
          end else begin
            w_state_nxt = IDLE;
            w_idx_nxt   = '0;
            w_gnt_nxt   = '0;
            w_valid_nxt = 1'b0;
          end
        end else if (r_hold == HW'(MAX_HOLD - 1)) begin
          // Timeout: owner still requesting, so w_found is guaranteed.
          w_ptr_nxt  = w_after;
          w_hold_nxt = '0;
          w_idx_nxt  = w_pick;
          w_gnt_nxt  = N'(1) << w_pick;
        end else begin
          w_hold_nxt = r_hold + HW'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt       = r_gnt;
    gnt_idx   = r_idx;
    gnt_valid = r_valid;
  end

endmodule

// File: tb/tb_rr_arb8.sv
// Self-checking bench for rr_arb8: cycle model plus directed literal checks.
// Model tracks owner and cycles-held; compared on every falling edge.
module tb_rr_arb8;

  localparam int MH = 16;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;

  int n_chk;
  int n_err;

  int m_owner;
  int m_ptr;
  int m_held;
  bit m_valid;
  bit m_live;

  rr_arb8 #(.MAX_HOLD(MH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int pick(input logic [7:0] v, input int start);
    for (int i = 0; i < 8; i++) begin
      if (v[(start + i) % 8]) return (start + i) % 8;
    end
    return -1;
  endfunction

  // Behavioural model: who owns the resource and for how many cycles.
  initial begin
    m_owner = 0;
    m_ptr   = 0;
    m_held  = 0;
    m_valid = 1'b0;
    m_live  = 1'b0;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b0;
      m_ptr   = 0;
      m_owner = 0;
      m_held  = 0;
      m_live  = 1'b1;
    end else if (!m_valid) begin
      if (req != 8'h00) begin
        m_owner = pick(req, m_ptr);
        m_valid = 1'b1;
        m_held  = 1;
      end
    end else if (!req[m_owner]) begin
      m_ptr = (m_owner + 1) % 8;
      if (req != 8'h00) begin
        m_owner = pick(req, m_ptr);
        m_held  = 1;
      end else begin
        m_valid = 1'b0;
        m_owner = 0;
        m_held  = 0;
      end
    end else if (m_held == MH) begin
      m_ptr   = (m_owner + 1) % 8;
      m_owner = pick(req, m_ptr);
      m_held  = 1;
    end else begin
      m_held++;
    end
  end

  always @(negedge clk) begin
    logic [7:0] eg;
    if (m_live) begin
      eg = m_valid ? (8'h01 << m_owner) : 8'h00;
      n_chk++;
      if (gnt !== eg || gnt_idx !== 3'(m_owner) || gnt_valid !== m_valid) begin
        n_err++;
        $display("FAIL model t=%0t got gnt=%h idx=%0d v=%b need gnt=%h idx=%0d v=%b",
                 $time, gnt, gnt_idx, gnt_valid, eg, m_owner, m_valid);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [7:0] g,
                     input logic [2:0] ix, input logic v);
    n_chk++;
    if (gnt !== g || gnt_idx !== ix || gnt_valid !== v) begin
      n_err++;
      $display("FAIL %s got gnt=%h idx=%0d v=%b need gnt=%h idx=%0d v=%b",
               nm, gnt, gnt_idx, gnt_valid, g, ix, v);
    end
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst = 1'b1;
    req = 8'h00;
    tick();
    tick();
    chk("reset", 8'h00, 3'd0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle", 8'h00, 3'd0, 1'b0);
    end

    req = 8'h24;
    tick();
    chk("first", 8'h04, 3'd2, 1'b1);
    req = 8'h20;
    tick();
    chk("handoff", 8'h20, 3'd5, 1'b1);
    req = 8'h00;
    tick();
    chk("release", 8'h00, 3'd0, 1'b0);

    req = 8'h80;
    tick();
    chk("own7", 8'h80, 3'd7, 1'b1);
    req = 8'hC1;
    tick();
    chk("hold7", 8'h80, 3'd7, 1'b1);
    req = 8'h41;
    tick();
    chk("wrap", 8'h01, 3'd0, 1'b1);
    req = 8'h00;
    tick();
    chk("idle2", 8'h00, 3'd0, 1'b0);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 8'h81;
    for (int k = 0; k < 64; k++) begin
      tick();
      if (((k / MH) % 2) == 0) chk("fair0", 8'h01, 3'd0, 1'b1);
      else chk("fair7", 8'h80, 3'd7, 1'b1);
    end

    req = 8'h08;
    tick();
    chk("sole0", 8'h08, 3'd3, 1'b1);
    for (int k = 0; k < 40; k++) begin
      tick();
      chk("sole", 8'h08, 3'd3, 1'b1);
    end

    req = 8'h00;
    tick();
    chk("idle3", 8'h00, 3'd0, 1'b0);
    req = 8'h10;
    tick();
    chk("own4", 8'h10, 3'd4, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    chk("midrst", 8'h00, 3'd0, 1'b0);
    rst = 1'b0;
    req = 8'h11;
    tick();
    chk("ptr0", 8'h01, 3'd0, 1'b1);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
